// File: rtl/ovl_fire_pkg.sv
// ovl_fire_pkg
//   Shared types and helpers for the OVL fire collector.
//   - evt_t          : {mask, ts} event record at the default sizes
//   - lowest_set_idx : index of the lowest set bit of a 16-bit vector
//   - ptr_w / PTR_W  : FIFO pointer width (address bits + 1 wrap bit)
package ovl_fire_pkg;

  localparam int DEF_NUM_CHK = 4;
  localparam int DEF_TS_W    = 16;
  localparam int DEF_DEPTH   = 4;

  // One extra pointer bit distinguishes full from empty when the
  // address bits match.
  localparam int PTR_W = $clog2(DEF_DEPTH) + 1;

  typedef struct packed {
    logic [DEF_NUM_CHK-1:0] mask;
    logic [DEF_TS_W-1:0]    ts;
  } evt_t;

  function automatic int ptr_w(int depth);
    return $clog2(depth) + 1;
  endfunction

  // Scan from the top down so the last hit is the lowest index.
  function automatic logic [3:0] lowest_set_idx(logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ovl_fire_collector_if.sv
// ovl_fire_collector_if
//   Event stream from the collector FIFO to its consumer.
//   evt_valid/evt_mask/evt_ts : head of FIFO (master drives)
//   evt_ready                 : consumer accepts head (slave drives)
interface ovl_fire_collector_if #(
  parameter int NUM_CHK = 4,
  parameter int TS_W    = 16
);
  logic               evt_valid;
  logic               evt_ready;
  logic [NUM_CHK-1:0] evt_mask;
  logic [TS_W-1:0]    evt_ts;

  modport master (output evt_valid, evt_mask, evt_ts, input evt_ready);
  modport slave  (input evt_valid, evt_mask, evt_ts, output evt_ready);
endinterface

// File: rtl/ovl_fire_fifo.sv
// ovl_fire_fifo
//   Synchronous DEPTH-entry FIFO, registered output path (no fall-through).
//   clock, reset (sync, active low), flush (empties, priority over push/pop)
//   push/din : write when asserted; caller must not push when full unless
//              it also pops in the same cycle
//   pop      : advance head; dout is the current head, full/empty flags
module ovl_fire_fifo
  import ovl_fire_pkg::*;
#(
  parameter int DW    = 20,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0]             wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH-1:0][DW-1:0]  mem_q, mem_d;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[PW-1] != rd_q[PW-1]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout  = mem_q[rd_q[AW-1:0]];

  // Push while full is legal only with a pop: the written slot is the
  // head being read out this same cycle.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (flush) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q[AW-1:0]] = din;
        wr_d = wr_q + PW'(1);
      end
      if (pop) rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: nothing is visible until a push lands.
  always_ff @(posedge clock) mem_q <= mem_d;

endmodule

// File: rtl/ovl_fire_collector.sv
// ovl_fire_collector
//   Collects OVL assertion-fire bits: saturating per-checker counts,
//   first-failure latch, free-running timestamp and a timestamped event
//   FIFO drained over a valid/ready interface.
//   clock, reset (sync, active low), enable, clear, fire_in[NUM_CHK]
//   evt (master)  : evt_valid/evt_mask/evt_ts out, evt_ready in
//   fail_cnt      : packed counts, checker i at [i*CNT_W +: CNT_W]
//   first_valid/first_id/first_ts, overflow (sticky), any_fail
//   Optional: OVL_FIRE_COLLECTOR_DISPLAY_EN prints event/first-fail lines.
module ovl_fire_collector
  import ovl_fire_pkg::*;
#(
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 8,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 4,
  localparam int FID_W  = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [NUM_CHK-1:0]       fire_in,
  ovl_fire_collector_if.master     evt,
  output logic [NUM_CHK*CNT_W-1:0] fail_cnt,
  output logic                     first_valid,
  output logic [FID_W-1:0]         first_id,
  output logic [TS_W-1:0]          first_ts,
  output logic                     overflow,
  output logic                     any_fail
);

  localparam int DW = NUM_CHK + TS_W;

  logic [TS_W-1:0]                ts_q, ts_d;
  logic [NUM_CHK-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic                           first_valid_q, first_valid_d;
  logic [FID_W-1:0]               first_id_q, first_id_d;
  logic [TS_W-1:0]                first_ts_q, first_ts_d;
  logic                           overflow_q, overflow_d;
  logic                           any_fail_q, any_fail_d;

  logic            evt_hit, push, pop, full, empty;
  logic [DW-1:0]   head;
  logic [15:0]     fire_ext;

  assign evt_hit = enable && (|fire_in);
  assign pop     = !empty && evt.evt_ready;
  // Full + pop frees the head slot this cycle, so the push still fits.
  assign push    = evt_hit && !clear && (!full || pop);

  always_comb begin
    fire_ext = '0;
    fire_ext[NUM_CHK-1:0] = fire_in;
  end

  always_comb begin
    ts_d          = ts_q + TS_W'(1);
    cnt_d         = cnt_q;
    first_valid_d = first_valid_q;
    first_id_d    = first_id_q;
    first_ts_d    = first_ts_q;
    overflow_d    = overflow_q;
    any_fail_d    = 1'b0;
    if (clear) begin
      cnt_d         = '0;
      first_valid_d = 1'b0;
      first_id_d    = '0;
      first_ts_d    = '0;
      overflow_d    = 1'b0;
    end else if (evt_hit) begin
      for (int i = 0; i < NUM_CHK; i++) begin
        if (fire_in[i] && (cnt_q[i] != {CNT_W{1'b1}}))
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      if (!first_valid_q) begin
        first_valid_d = 1'b1;
        first_id_d    = FID_W'(lowest_set_idx(fire_ext));
        first_ts_d    = ts_q;
      end
      if (full && !pop) overflow_d = 1'b1;
    end
    // Taken from next-state so any_fail moves with the counts.
    for (int i = 0; i < NUM_CHK; i++) begin
      if (cnt_d[i] != '0) any_fail_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ts_q          <= '0;
      cnt_q         <= '0;
      first_valid_q <= 1'b0;
      first_id_q    <= '0;
      first_ts_q    <= '0;
      overflow_q    <= 1'b0;
      any_fail_q    <= 1'b0;
    end else begin
      ts_q          <= ts_d;
      cnt_q         <= cnt_d;
      first_valid_q <= first_valid_d;
      first_id_q    <= first_id_d;
      first_ts_q    <= first_ts_d;
      overflow_q    <= overflow_d;
      any_fail_q    <= any_fail_d;
    end
  end

  ovl_fire_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (clear),
    .push  (push),
    .pop   (pop),
    .din   ({fire_in, ts_q}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // Head fields are forced to zero while empty so stale storage never shows.
  assign evt.evt_valid = !empty;
  assign evt.evt_mask  = empty ? '0 : head[DW-1:TS_W];
  assign evt.evt_ts    = empty ? '0 : head[TS_W-1:0];

  assign fail_cnt    = cnt_q;
  assign first_valid = first_valid_q;
  assign first_id    = first_id_q;
  assign first_ts    = first_ts_q;
  assign overflow    = overflow_q;
  assign any_fail    = any_fail_q;

`ifdef OVL_FIRE_COLLECTOR_DISPLAY_EN
  always_ff @(posedge clock) begin
    if (reset && !clear && evt_hit) begin
      $display("OVL_FIRE t=%0d mask=%h %s", ts_q, fire_in,
               push ? "ACCEPTED" : "DROPPED");
      if (!first_valid_q) $display("OVL_FIRE FIRST id=%0d", first_id_d);
    end
  end
`else
`endif

endmodule

// File: tb/tb_ovl_fire_collector.sv
module tb_ovl_fire_collector;
  import ovl_fire_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  fire_in = '0;
  logic [31:0] fail_cnt;
  logic        first_valid;
  logic [1:0]  first_id;
  logic [15:0] first_ts;
  logic        overflow;
  logic        any_fail;

  int errs = 0;
  int checks = 0;
  logic [15:0] ts_m = '0;

  ovl_fire_collector_if #(.NUM_CHK(4), .TS_W(16)) evt_if ();

  ovl_fire_collector #(.NUM_CHK(4), .CNT_W(8), .TS_W(16), .DEPTH(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .clear       (clear),
    .fire_in     (fire_in),
    .evt         (evt_if),
    .fail_cnt    (fail_cnt),
    .first_valid (first_valid),
    .first_id    (first_id),
    .first_ts    (first_ts),
    .overflow    (overflow),
    .any_fail    (any_fail)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock; ts_m tracks the cycle timestamp as seen after the edge.
  task automatic step();
    @(posedge clock);
    ts_m = reset ? ts_m + 16'd1 : 16'd0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    reset = 1'b1;
  endtask

  logic [15:0] t0, t_acc, d_first, d_last;
  int n;

  initial begin
    evt_if.evt_ready = 1'b0;

    // Reset / idle
    reset = 1'b0;
    step(); step();
    chk("rst_valid", evt_if.evt_valid, 0);
    chk("rst_mask", evt_if.evt_mask, 0);
    chk("rst_ts", evt_if.evt_ts, 0);
    chk("rst_cnt", fail_cnt, 0);
    chk("rst_first", {first_valid, first_id, first_ts}, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_any", any_fail, 0);
    reset = 1'b1;
    repeat (10) step();
    chk("idle_valid", evt_if.evt_valid, 0);
    chk("idle_cnt", fail_cnt, 0);
    chk("idle_first", first_valid, 0);

    // Single fire at ts=5
    do_reset();
    repeat (5) step();
    fire_in = 4'b0100;
    step();
    fire_in = '0;
    chk("one_cnt", fail_cnt, 32'h0001_0000);
    chk("one_fv", first_valid, 1);
    chk("one_fid", first_id, 2);
    chk("one_fts", first_ts, 5);
    chk("one_valid", evt_if.evt_valid, 1);
    chk("one_mask", evt_if.evt_mask, 4'b0100);
    chk("one_ets", evt_if.evt_ts, 5);
    chk("one_any", any_fail, 1);
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    chk("one_popped", evt_if.evt_valid, 0);

    // Simultaneous fires
    do_reset();
    step();
    fire_in = 4'b1010;
    step();
    fire_in = '0;
    chk("sim_fid", first_id, 1);
    chk("sim_fts", first_ts, 1);
    chk("sim_cnt", fail_cnt, 32'h0100_0100);
    chk("sim_mask", evt_if.evt_mask, 4'b1010);
    evt_if.evt_ready = 1'b1;
    step();
    evt_if.evt_ready = 1'b0;
    chk("sim_single", evt_if.evt_valid, 0);

    // Overflow, then push while popping at full
    do_reset();
    step();
    t0 = ts_m;
    fire_in = 4'b0001;
    repeat (5) step();
    chk("ovf_set", overflow, 1);
    chk("ovf_cnt", fail_cnt, 32'd5);
    chk("ovf_head", evt_if.evt_ts, 64'(t0));
    evt_if.evt_ready = 1'b1;
    t_acc = ts_m;
    step();
    fire_in = '0;
    chk("ovf_hold", overflow, 1);
    chk("ovf_cnt6", fail_cnt, 32'd6);
    n = 0;
    d_first = '0;
    d_last = '0;
    for (int k = 0; k < 10; k++) begin
      if (evt_if.evt_valid) begin
        if (n == 0) d_first = evt_if.evt_ts;
        d_last = evt_if.evt_ts;
        n++;
      end
      step();
    end
    chk("drain_n", n, 4);
    chk("drain_first", d_first, 64'(t0 + 16'd1));
    chk("drain_last", d_last, 64'(t_acc));

    // Saturation
    do_reset();
    fire_in = 4'b0001;
    repeat (300) step();
    chk("sat_cnt", fail_cnt, 32'h0000_00FF);
    repeat (5) step();
    fire_in = '0;
    chk("sat_hold", fail_cnt, 32'h0000_00FF);
    chk("sat_any", any_fail, 1);

    // Clear with simultaneous fire
    evt_if.evt_ready = 1'b0;
    fire_in = 4'b0010;
    repeat (6) step();
    chk("clr_pre_ovf", overflow, 1);
    clear = 1'b1;
    fire_in = 4'b0100;
    step();
    clear = 1'b0;
    fire_in = '0;
    chk("clr_cnt", fail_cnt, 0);
    chk("clr_first", {first_valid, first_id, first_ts}, 0);
    chk("clr_ovf", overflow, 0);
    chk("clr_valid", evt_if.evt_valid, 0);
    chk("clr_any", any_fail, 0);
    step();
    chk("clr_discard", evt_if.evt_valid, 0);

    // Enable low ignores fires
    enable = 1'b0;
    fire_in = 4'b1111;
    repeat (3) step();
    fire_in = '0;
    chk("en_cnt", fail_cnt, 0);
    chk("en_valid", evt_if.evt_valid, 0);
    chk("en_first", first_valid, 0);
    enable = 1'b1;
    t0 = ts_m;
    fire_in = 4'b1000;
    step();
    fire_in = '0;
    chk("en_fid", first_id, 3);
    chk("en_fts", first_ts, 64'(t0));
    chk("en_cnt3", fail_cnt, 32'h0100_0000);

    // Reset mid-operation
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("mid_valid", evt_if.evt_valid, 0);
    chk("mid_cnt", fail_cnt, 0);
    chk("mid_first", first_valid, 0);
    chk("mid_any", any_fail, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
